// File: rtl/fifo_frame_reader_if.sv
// rtl/fifo_frame_reader_if.sv - sample stream from the frame reader to the FFT/FIR stage
interface fifo_frame_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fifo_frame_reader.sv
// rtl/fifo_frame_reader.sv - drains the sample FIFO into fixed-length frames; FIFO_FRAME_READER_FILL_GATE_EN holds each frame until fully resident
module fifo_frame_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int LEVEL_WIDTH = 11,
  parameter int RD_LATENCY  = 1,
  parameter int FRAME_LEN   = 1024,
  parameter int FCNT_WIDTH  = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst_n,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                   fifo_rd_en,
  fifo_frame_reader_if.master    m_if,
  output logic [FCNT_WIDTH-1:0]  frame_cnt,
  output logic                   busy
);
  localparam int BUF_DEPTH = RD_LATENCY + 2;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int INF_W     = CNT_W + 1;
  localparam logic [LEVEL_WIDTH-1:0] FRAME_LEN_L = LEVEL_WIDTH'(FRAME_LEN);
  localparam logic [LEVEL_WIDTH-1:0] LAST_IDX    = LEVEL_WIDTH'(FRAME_LEN - 1);
  localparam logic [PTR_W-1:0]       PTR_MAX     = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                 state_q, state_d;
  logic [LEVEL_WIDTH-1:0] issued_q, issued_d;
  logic [LEVEL_WIDTH-1:0] sent_q, sent_d;
  logic [RD_LATENCY-1:0]  pipe_q, pipe_d;
  logic [DATA_WIDTH-1:0]  mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [FCNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic [INF_W-1:0]       inflight;
  logic                   start, push, pop;

`ifdef FIFO_FRAME_READER_FILL_GATE_EN
  assign start = fifo_rd_water_level >= FRAME_LEN_L;
`else
  logic unused_level;
  assign unused_level = ^fifo_rd_water_level;
  assign start = ~fifo_rd_empty;
`endif

  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q == STREAM);

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    sent_d      = sent_q;
    frame_cnt_d = frame_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_d       = mem_q;

    // Reads still in the latency pipe already own a buffer slot.
    inflight = INF_W'(count_q);
    for (int i = 0; i < RD_LATENCY; i++) begin
      if (pipe_q[i]) inflight = inflight + INF_W'(1);
    end

    fifo_rd_en = (state_q == STREAM) & ~fifo_rd_empty & (issued_q < FRAME_LEN_L)
               & (inflight < INF_W'(BUF_DEPTH));
    pipe_d     = (pipe_q << 1) | RD_LATENCY'(fifo_rd_en);

    m_if.m_valid = (count_q != '0);
    m_if.m_data  = mem_q[rd_ptr_q];
    m_if.m_last  = m_if.m_valid & (sent_q == LAST_IDX);

    push = pipe_q[RD_LATENCY-1];
    pop  = m_if.m_valid & m_if.m_ready;

    if (fifo_rd_en) issued_d = issued_q + LEVEL_WIDTH'(1);

    if (push) begin
      mem_d[wr_ptr_q] = fifo_rd_data;
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);

    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    if (state_q == IDLE && start) state_d = STREAM;

    if (pop) begin
      if (m_if.m_last) begin
        sent_d      = '0;
        issued_d    = '0;
        frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(1);
        state_d     = IDLE;
      end else begin
        sent_d = sent_q + LEVEL_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q     <= IDLE;
      issued_q    <= '0;
      sent_q      <= '0;
      pipe_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_cnt_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      sent_q      <= sent_d;
      pipe_q      <= pipe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_cnt_q <= frame_cnt_d;
      mem_q       <= mem_d;
    end
  end
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb/tb_fifo_frame_reader.sv - scoreboard bench for fifo_frame_reader against a FIFO model with read latency
module tb_fifo_frame_reader;
  localparam int DW = 32, LW = 11, LAT = 2, FL = 8, FCW = 2;
  localparam int BUF_DEPTH = LAT + 2;

  logic           rd_clk = 1'b0;
  logic           rd_rst_n = 1'b0;
  logic [DW-1:0]  fifo_rd_data;
  logic           fifo_rd_empty;
  logic [LW-1:0]  fifo_rd_water_level;
  logic           fifo_rd_en;
  logic [FCW-1:0] frame_cnt;
  logic           busy;

  fifo_frame_reader_if #(.DATA_WIDTH(DW)) s_if ();

  fifo_frame_reader #(
    .DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .RD_LATENCY(LAT), .FRAME_LEN(FL), .FCNT_WIDTH(FCW)
  ) dut (
    .rd_clk(rd_clk),
    .rd_rst_n(rd_rst_n),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level),
    .fifo_rd_en(fifo_rd_en),
    .m_if(s_if),
    .frame_cnt(frame_cnt),
    .busy(busy)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: words appear LAT cycles after the read enable edge
  logic [DW-1:0] fmem [0:255];
  int            wr_count = 0;
  int            rd_ptr = 0;
  logic          flush = 1'b0;
  logic [DW-1:0] d0 = '0, d1 = '0;

  assign fifo_rd_empty       = (rd_ptr == wr_count);
  assign fifo_rd_water_level = LW'(wr_count - rd_ptr);
  assign fifo_rd_data        = (LAT == 1) ? d0 : d1;

  always @(posedge rd_clk) begin
    if (flush) begin
      rd_ptr <= wr_count;
      d0 <= '0;
      d1 <= '0;
    end else begin
      if (fifo_rd_en) begin
        d0 <= fmem[rd_ptr % 256];
        rd_ptr <= rd_ptr + 1;
      end
      d1 <= d0;
    end
  end

  int rd_total = 0, hs_total = 0;
  always @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_total <= 0;
      hs_total <= 0;
    end else begin
      if (fifo_rd_en) rd_total <= rd_total + 1;
      if (s_if.m_valid && s_if.m_ready) hs_total <= hs_total + 1;
    end
  end

  int            checks = 0, failures = 0;
  logic [DW:0]   exp_q [$];
  int            sb_idx = 0;
  int            hs_at [0:63];

  task automatic push_word(input logic [DW-1:0] d);
    fmem[wr_count % 256] = d;
    wr_count++;
    exp_q.push_back({((sb_idx % FL) == FL - 1), d});
    sb_idx++;
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rd_rst_n = 1'b0;
    s_if.m_ready = 1'b0;
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    exp_q.delete();
    sb_idx = 0;
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
  endtask

  task automatic drain(input int n, input bit toggle);
    int got = 0;
    int k = 0;
    bit stall = 1'b0;
    logic [DW-1:0] held = '0;
    logic [DW:0] e;
    while (got < n && k < n * 8 + 50) begin
      @(negedge rd_clk);
      s_if.m_ready = toggle ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
      if (stall) begin
        checks++;
        if (s_if.m_valid !== 1'b1 || s_if.m_data !== held) begin
          failures++;
          $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", s_if.m_valid, s_if.m_data, held);
        end
      end
      if (fifo_rd_en === 1'b1) begin
        checks++;
        if (rd_total - hs_total >= BUF_DEPTH) begin
          failures++;
          $display("FAIL credit: read issued with inflight=%0d required below %0d", rd_total - hs_total, BUF_DEPTH);
        end
      end
      stall = s_if.m_valid && !s_if.m_ready;
      held  = s_if.m_data;
      if (s_if.m_valid && s_if.m_ready) begin
        if (got < 64) hs_at[got] = k;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sample: unexpected sample %h last=%b required none", s_if.m_data, s_if.m_last);
        end else begin
          e = exp_q.pop_front();
          if ({s_if.m_last, s_if.m_data} !== e) begin
            failures++;
            $display("FAIL sample: last=%b data=%h required last=%b data=%h", s_if.m_last, s_if.m_data, e[DW], e[DW-1:0]);
          end
        end
        got++;
      end
      k++;
    end
    checks++;
    if (got !== n) begin
      failures++;
      $display("FAIL drain_count: got %0d samples required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    s_if.m_ready = 1'b0;
    repeat (2) @(negedge rd_clk);
    checks++;
    if ({fifo_rd_en, s_if.m_valid, s_if.m_last, s_if.m_data, frame_cnt, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: en=%b valid=%b last=%b data=%h cnt=%0d busy=%b required all 0",
               fifo_rd_en, s_if.m_valid, s_if.m_last, s_if.m_data, frame_cnt, busy);
    end
    rd_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat = 0;
    @(negedge rd_clk);
    s_if.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_word(DW'(i));
    while (s_if.m_valid !== 1'b1 && lat < 20) begin
      @(negedge rd_clk);
      lat++;
    end
    checks++;
    if (lat !== LAT + 2) begin
      failures++;
      $display("FAIL first_latency: %0d cycles required %0d", lat, LAT + 2);
    end
    drain(16, 1'b0);
    checks++;
    if (hs_at[7] - hs_at[0] !== FL - 1) begin
      failures++;
      $display("FAIL throughput: frame took %0d cycles required %0d", hs_at[7] - hs_at[0], FL - 1);
    end
    checks++;
    if (hs_at[8] - hs_at[7] < 2) begin
      failures++;
      $display("FAIL frame_bubble: gap %0d required at least 2", hs_at[8] - hs_at[7]);
    end
    @(negedge rd_clk);
    checks++;
    if (busy !== 1'b0 || frame_cnt !== FCW'(2)) begin
      failures++;
      $display("FAIL basic_end: busy=%b cnt=%0d required busy=0 cnt=2", busy, frame_cnt);
    end
  endtask

  task automatic test_stall();
    @(negedge rd_clk);
    for (int i = 0; i < 16; i++) push_word(DW'(32'h1000 + i));
    drain(16, 1'b1);
    @(negedge rd_clk);
    checks++;
    if (busy !== 1'b0 || frame_cnt !== FCW'(0)) begin
      failures++;
      $display("FAIL stall_end: busy=%b cnt=%0d required busy=0 cnt=0", busy, frame_cnt);
    end
  endtask

`ifdef FIFO_FRAME_READER_FILL_GATE_EN
  task automatic test_fill_gate();
    bit saw = 1'b0;
    @(negedge rd_clk);
    for (int i = 0; i < 5; i++) push_word(DW'(32'h300 + i));
    for (int c = 0; c < 10; c++) begin
      @(negedge rd_clk);
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++;
      $display("FAIL fill_gate_hold: activity seen=%b required 0", saw);
    end
    for (int i = 5; i < 8; i++) push_word(DW'(32'h300 + i));
    @(negedge rd_clk);
    checks++;
    if (busy !== 1'b1 || fifo_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL fill_gate_start: busy=%b en=%b required 1 1", busy, fifo_rd_en);
    end
    drain(8, 1'b0);
    @(negedge rd_clk);
    checks++;
    if (frame_cnt !== FCW'(1)) begin
      failures++;
      $display("FAIL fill_gate_cnt: %0d required 1", frame_cnt);
    end
  endtask
`else
  task automatic test_empty_gap();
    bit saw_valid = 1'b0;
    bit saw_idle = 1'b0;
    @(negedge rd_clk);
    for (int i = 0; i < 3; i++) push_word(DW'(32'h300 + i));
    drain(3, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge rd_clk);
      if (s_if.m_valid !== 1'b0) saw_valid = 1'b1;
      if (busy !== 1'b1) saw_idle = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0 || saw_idle !== 1'b0) begin
      failures++;
      $display("FAIL gap_hold: valid seen=%b idle seen=%b required 0 0", saw_valid, saw_idle);
    end
    for (int i = 3; i < 8; i++) push_word(DW'(32'h300 + i));
    drain(5, 1'b0);
    @(negedge rd_clk);
    checks++;
    if (frame_cnt !== FCW'(1) || busy !== 1'b0) begin
      failures++;
      $display("FAIL gap_end: cnt=%0d busy=%b required cnt=1 busy=0", frame_cnt, busy);
    end
  endtask
`endif

  task automatic test_midframe_reset();
    @(negedge rd_clk);
    for (int i = 0; i < 8; i++) push_word(DW'(32'h200 + i));
    drain(5, 1'b0);
    @(negedge rd_clk);
    rd_rst_n = 1'b0;
    #1;
    checks++;
    if ({fifo_rd_en, s_if.m_valid, s_if.m_last, s_if.m_data, frame_cnt, busy} !== '0) begin
      failures++;
      $display("FAIL midframe_reset: en=%b valid=%b last=%b data=%h cnt=%0d busy=%b required all 0",
               fifo_rd_en, s_if.m_valid, s_if.m_last, s_if.m_data, frame_cnt, busy);
    end
    s_if.m_ready = 1'b0;
    flush = 1'b1;
    exp_q.delete();
    sb_idx = 0;
    @(negedge rd_clk);
    flush = 1'b0;
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) push_word(DW'(100 + i));
    drain(8, 1'b0);
    @(negedge rd_clk);
    checks++;
    if (frame_cnt !== FCW'(1)) begin
      failures++;
      $display("FAIL midframe_cnt: %0d required 1", frame_cnt);
    end
  endtask

  task automatic test_fcnt_wrap();
    logic [FCW-1:0] want;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 8; i++) push_word(DW'(32'h4000 + f * 16 + i));
      drain(8, f[0]);
      @(negedge rd_clk);
      want = FCW'(f + 1);
      checks++;
      if (frame_cnt !== want) begin
        failures++;
        $display("FAIL fcnt_wrap: frame %0d cnt=%0d required %0d", f, frame_cnt, want);
      end
    end
  endtask

  initial begin
    s_if.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
`ifdef FIFO_FRAME_READER_FILL_GATE_EN
    test_fill_gate();
`else
    test_empty_gap();
`endif
    test_midframe_reset();
    test_fcnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
- Drains the read port of the audio sample FIFO and emits fixed-length frames on a valid/ready stream for the FFT/FIR stage.
- Issues FIFO read enables against a small internal credit buffer, so it absorbs 1- or 2-cycle FIFO read latency (output register off/on) without losing data when downstream stalls.
- Marks the last sample of every frame and counts completed frames.

Parameters:
- DATA_WIDTH, 32, sample width; equals the FIFO read data width.
- LEVEL_WIDTH, 11, width of the FIFO read water level input; equals FIFO read depth width + 1.
- RD_LATENCY, 1, cycles from fifo_rd_en to valid fifo_rd_data; legal values 1 or 2.
- FRAME_LEN, 1024, samples per frame; legal range 2..2^(LEVEL_WIDTH-1).
- FCNT_WIDTH, 16, width of the completed-frame counter.

Ports:
- rd_clk  in  1  single clock; the FIFO read clock.
- rd_rst_n  in  1  asynchronous, active-low reset.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data.
- fifo_rd_empty  in  1  FIFO empty flag.
- fifo_rd_water_level  in  LEVEL_WIDTH  FIFO read-side occupancy.
- fifo_rd_en  out  1  FIFO read enable, one word per asserted cycle.
- m_data  out  DATA_WIDTH  output sample.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts when m_valid & m_ready.
- m_last  out  1  high with the final sample of a frame.
- frame_cnt  out  FCNT_WIDTH  completed frames, wraps modulo 2^FCNT_WIDTH.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock, rd_clk. Reset is asynchronous and active-low on rd_rst_n.
- Reset values: all outputs 0; buffer empty; counters 0; state IDLE.
- Reset mid-frame: the partial frame is discarded. The FIFO must be reset alongside this block.
- States:
  - IDLE -> STREAM when the start condition holds (see Optional Feature).
  - STREAM -> IDLE on the cycle m_last handshakes.
- Internal buffer: circular, BUF_DEPTH = RD_LATENCY+2 entries. inflight = reads issued but not yet returned, plus entries held in the buffer.
- fifo_rd_en = (state==STREAM) & ~fifo_rd_empty & (issued < FRAME_LEN) & (inflight < BUF_DEPTH). It is combinational from registered state and FIFO flags.
- Each fifo_rd_en increments issued. A delay line of depth RD_LATENCY, reset 0, tracks it; at its output, fifo_rd_data is written into the buffer.
- Buffer can never overflow, by the credit rule. A return and a pop in the same cycle are both honoured.
- Output:
  - m_valid = buffer non-empty; m_data = buffer head, held stable while m_valid & ~m_ready.
  - m_last = m_valid & (sent == FRAME_LEN-1).
  - Each handshake increments sent.
- On the m_last handshake: issued and sent clear to 0, frame_cnt increments (2^FCNT_WIDTH-1 wraps to 0), state -> IDLE.
- No read is issued for the next frame before state returns to IDLE, so frames never interleave. The bubble between frames is at least 1 cycle.
- FIFO empty mid-frame: fifo_rd_en drops and m_valid drops once the buffer drains; the frame resumes with no duplicated or lost samples.
- Steady-state throughput with m_ready held high: 1 sample/cycle.
- First-sample latency from STREAM entry: RD_LATENCY+1 cycles.

Optional Feature:
- Macro: FIFO_FRAME_READER_FILL_GATE_EN.
- Defined: IDLE -> STREAM only when fifo_rd_water_level >= FRAME_LEN. The whole frame is then already resident and streams without FIFO-side gaps.
- Undefined: IDLE -> STREAM whenever ~fifo_rd_empty; fifo_rd_water_level is unused. Mid-frame empty gaps follow the rule above.

Test Plan:
- FRAME_LEN=8, RD_LATENCY=1, FIFO pre-loaded with 0..15, m_ready=1 -> two frames 0..7 and 8..15; m_last on samples 7 and 15; frame_cnt=2; busy low after the last handshake.
- RD_LATENCY=2, m_ready toggling 1,0,0,1 repeating -> fifo_rd_en never asserted while inflight=4; m_data stable during stalls; output sequence exact; no overflow.
- Fill gate defined, FRAME_LEN=8, write 5 words -> fifo_rd_en stays 0. Write 3 more -> streaming starts within 1 cycle of level=8.
- Fill gate undefined, 3 words present then 5 more after a 20-cycle gap -> m_valid drops after sample 2; samples 3..7 follow in order; m_last only on sample 7.
- Assert rd_rst_n=0 after sample 4 of a frame -> all outputs 0 immediately. After release and FIFO refill with 100..107 -> clean frame 100..107, frame_cnt=1.
- FCNT_WIDTH=2, 5 frames -> frame_cnt sequence 1,2,3,0,1.
